// File: rtl/vga_pkg.sv
// Shared constants and types for the double-buffered VGA frame buffer.
// Geometry, pixel/address types and controller state encoding.
package vga_pkg;

  localparam int FB_W      = 192;
  localparam int FB_H      = 108;
  localparam int AW        = 15;
  localparam int DW        = 24;
  localparam int FB_PIXELS = FB_W * FB_H;

  typedef logic [AW-1:0] addr_t;
  typedef logic [DW-1:0] pixel_t;

  localparam addr_t PIX_END  = AW'(FB_PIXELS);
  localparam addr_t PIX_LAST = AW'(FB_PIXELS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SWAP_WAIT
  } fb_state_e;

  function automatic logic in_fb(addr_t a);
    return a < PIX_END;
  endfunction

endpackage

// File: rtl/vga_fb_ctrl_if.sv
// Producer write port into the back bank of the frame buffer.
// Valid/ready handshake plus an out-of-range error pulse.
interface vga_fb_ctrl_if;
  import vga_pkg::*;

  logic   wr_valid;
  logic   wr_ready;
  addr_t  wr_addr;
  pixel_t wr_data;
  logic   wr_err;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready,
    input  wr_err
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready,
    output wr_err
  );

endinterface

// File: rtl/fb_bank_ram.sv
// One frame-buffer bank: synchronous write, registered read.
// Contents are intentionally not reset.
module fb_bank_ram
  import vga_pkg::*;
(
  input  logic   clk,
  input  logic   we_i,
  input  addr_t  waddr_i,
  input  pixel_t wdata_i,
  input  addr_t  raddr_i,
  output pixel_t rdata_o
);

  pixel_t mem_q [2**AW];
  pixel_t rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_fb_ctrl.sv
// Double-buffered frame-buffer controller: display reads front bank,
// producer/clear fill the back bank, swaps land on vs falling edges.
module vga_fb_ctrl
  import vga_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          vs_in,
  input  addr_t         rd_addr,
  output pixel_t        rd_data,
  vga_fb_ctrl_if.slave  wr,
  input  logic          clear_req,
  input  pixel_t        clear_color,
  output logic          clear_busy,
  input  logic          swap_req,
  output logic          swap_pending,
  output logic          swap_done,
  output logic          front_sel
);

  fb_state_e state_q;
  addr_t     cnt_q;
  pixel_t    color_q;
  logic      vs_d_q;
  logic      front_sel_q;
  logic      wr_ready_q;
  logic      wr_err_q;
  logic      clear_busy_q;
  logic      swap_pending_q;
  logic      swap_done_q;
  logic      rd_sel_q;
  logic      rd_oor_q;

  logic   vs_fall;
  logic   wr_acc;
  logic   wr_in;
  logic   clr_we;
  logic   clear_done;
  logic   bank_we;
  addr_t  bank_waddr;
  pixel_t bank_wdata;
  pixel_t q0;
  pixel_t q1;

  assign vs_fall    = vs_d_q & ~vs_in;
  assign wr_acc     = wr.wr_valid & wr_ready_q;
  assign wr_in      = in_fb(wr.wr_addr);
  assign clr_we     = (state_q == ST_CLEAR);
  assign clear_done = clr_we && (cnt_q == PIX_LAST);

  // Clear and producer writes never overlap: wr_ready is low in CLEAR.
  assign bank_we    = clr_we | (wr_acc & wr_in);
  assign bank_waddr = clr_we ? cnt_q   : wr.wr_addr;
  assign bank_wdata = clr_we ? color_q : wr.wr_data;

  fb_bank_ram u_bank0 (
    .clk     (clk),
    .we_i    (bank_we & front_sel_q),
    .waddr_i (bank_waddr),
    .wdata_i (bank_wdata),
    .raddr_i (rd_addr),
    .rdata_o (q0)
  );

  fb_bank_ram u_bank1 (
    .clk     (clk),
    .we_i    (bank_we & ~front_sel_q),
    .waddr_i (bank_waddr),
    .wdata_i (bank_wdata),
    .raddr_i (rd_addr),
    .rdata_o (q1)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      color_q        <= '0;
      vs_d_q         <= 1'b1;
      front_sel_q    <= 1'b0;
      wr_ready_q     <= 1'b0;
      wr_err_q       <= 1'b0;
      clear_busy_q   <= 1'b0;
      swap_pending_q <= 1'b0;
      swap_done_q    <= 1'b0;
      rd_sel_q       <= 1'b0;
      rd_oor_q       <= 1'b1;
    end else begin
      vs_d_q      <= vs_in;
      swap_done_q <= 1'b0;
      wr_err_q    <= wr_acc & ~wr_in;
      // Bank select is captured with the address so a swap never splits a read.
      rd_sel_q    <= front_sel_q;
      rd_oor_q    <= ~in_fb(rd_addr);
      unique case (state_q)
        ST_IDLE: begin
          if (clear_req) begin
            state_q        <= ST_CLEAR;
            cnt_q          <= '0;
            color_q        <= clear_color;
            clear_busy_q   <= 1'b1;
            wr_ready_q     <= 1'b0;
            swap_pending_q <= swap_req;
          end else if (swap_req) begin
            state_q        <= ST_SWAP_WAIT;
            wr_ready_q     <= 1'b0;
            swap_pending_q <= 1'b1;
          end else begin
            wr_ready_q     <= 1'b1;
          end
        end
        ST_CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (swap_req) swap_pending_q <= 1'b1;
          if (clear_done) begin
            clear_busy_q <= 1'b0;
            if (swap_pending_q | swap_req) begin
              state_q <= ST_SWAP_WAIT;
            end else begin
              state_q    <= ST_IDLE;
              wr_ready_q <= 1'b1;
            end
          end
        end
        ST_SWAP_WAIT: begin
          if (vs_fall) begin
            front_sel_q    <= ~front_sel_q;
            swap_done_q    <= 1'b1;
            swap_pending_q <= 1'b0;
            state_q        <= ST_IDLE;
            wr_ready_q     <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rd_data      = rd_oor_q ? '0 : (rd_sel_q ? q1 : q0);
  assign wr.wr_ready  = wr_ready_q;
  assign wr.wr_err    = wr_err_q;
  assign clear_busy   = clear_busy_q;
  assign swap_pending = swap_pending_q;
  assign swap_done    = swap_done_q;
  assign front_sel    = front_sel_q;

endmodule

// File: tb/tb_vga_fb_ctrl.sv
// Directed self-checking bench for vga_fb_ctrl.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_vga_fb_ctrl;
  import vga_pkg::*;

  logic   clk = 1'b0;
  logic   reset_n;
  logic   vs_in;
  addr_t  rd_addr;
  pixel_t rd_data;
  logic   clear_req;
  pixel_t clear_color;
  logic   clear_busy;
  logic   swap_req;
  logic   swap_pending;
  logic   swap_done;
  logic   front_sel;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc;
  int bad;

  always #5 clk = ~clk;

  vga_fb_ctrl_if wr_if ();

  vga_fb_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .vs_in        (vs_in),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .wr           (wr_if),
    .clear_req    (clear_req),
    .clear_color  (clear_color),
    .clear_busy   (clear_busy),
    .swap_req     (swap_req),
    .swap_pending (swap_pending),
    .swap_done    (swap_done),
    .front_sel    (front_sel)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ne(input string tag, input logic [31:0] obs,
                        input logic [31:0] bad_val);
    n_chk++;
    assert (obs !== bad_val) else begin
      n_fail++;
      $error("FAIL %s: observed %h must differ from %h", tag, obs, bad_val);
    end
  endtask

  task automatic nclk();
    @(negedge clk);
  endtask

  initial begin
    reset_n          = 1'b0;
    vs_in            = 1'b1;
    rd_addr          = '0;
    clear_req        = 1'b0;
    clear_color      = '0;
    swap_req         = 1'b0;
    wr_if.wr_valid   = 1'b0;
    wr_if.wr_addr    = '0;
    wr_if.wr_data    = '0;
    nclk(); nclk();
    chk("rst_wr_ready", wr_if.wr_ready, 0);
    chk("rst_front", front_sel, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_busy", clear_busy, 0);
    chk("rst_pending", swap_pending, 0);
    reset_n = 1'b1;
    nclk();
    chk("post_rst_ready", wr_if.wr_ready, 1);

    // write + swap on frame boundary
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr  = 15'd5;
    wr_if.wr_data  = 24'hFF0000;
    nclk();
    wr_if.wr_valid = 1'b0;
    swap_req = 1'b1;
    rd_addr  = 15'd5;
    nclk();
    swap_req = 1'b0;
    chk("sw_pending", swap_pending, 1);
    chk("sw_wait_ready", wr_if.wr_ready, 0);
    chk_ne("no_tear_pre", rd_data, 32'hFF0000);
    vs_in = 1'b0;
    nclk();
    chk("sw_done", swap_done, 1);
    chk("sw_front", front_sel, 1);
    chk_ne("no_tear_edge", rd_data, 32'hFF0000);
    nclk();
    chk("sw_rd_new", rd_data, 24'hFF0000);
    chk("sw_done_pulse", swap_done, 0);
    chk("sw_pending_clr", swap_pending, 0);
    chk("sw_ready_back", wr_if.wr_ready, 1);

    // out-of-range write and read
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr  = 15'd20736;
    wr_if.wr_data  = 24'hABCDEF;
    nclk();
    wr_if.wr_addr  = 15'd20735;
    wr_if.wr_data  = 24'h0000AA;
    chk("wr_err_pulse", wr_if.wr_err, 1);
    nclk();
    wr_if.wr_valid = 1'b0;
    chk("wr_err_inrange", wr_if.wr_err, 0);
    rd_addr = 15'd30000;
    nclk();
    chk("rd_oor_30000", rd_data, 0);
    rd_addr = 15'd20736;
    nclk();
    chk("rd_oor_20736", rd_data, 0);

    // clear with simultaneous swap request
    clear_req   = 1'b1;
    clear_color = 24'h00FF00;
    swap_req    = 1'b1;
    nclk();
    clear_req = 1'b0;
    swap_req  = 1'b0;
    chk("clr_pending", swap_pending, 1);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr  = 15'd7;
    wr_if.wr_data  = 24'hDEAD00;
    cyc = 0;
    bad = 0;
    while (clear_busy && cyc < 25000) begin
      if (wr_if.wr_ready !== 1'b0) bad++;
      if (cyc == 100) begin
        clear_req   = 1'b1;
        clear_color = 24'h0000FF;
      end else begin
        clear_req = 1'b0;
      end
      cyc++;
      nclk();
    end
    wr_if.wr_valid = 1'b0;
    clear_req = 1'b0;
    chk("clr_busy_cycles", cyc, 20736);
    chk("clr_ready_low", bad, 0);
    chk("clr_wait_pending", swap_pending, 1);
    chk("clr_wait_front", front_sel, 1);
    vs_in = 1'b1;
    nclk(); nclk();
    vs_in = 1'b0;
    nclk();
    chk("clr_swap_done", swap_done, 1);
    chk("clr_swap_front", front_sel, 0);

    rd_addr = '0;
    bad = 0;
    nclk();
    for (int i = 1; i <= FB_PIXELS; i++) begin
      if (rd_data !== 24'h00FF00) bad++;
      rd_addr = AW'(i);
      nclk();
    end
    chk("clr_all_green", bad, 0);

    // swap request coinciding with a frame boundary
    vs_in = 1'b1;
    nclk();
    swap_req = 1'b1;
    vs_in    = 1'b0;
    nclk();
    swap_req = 1'b0;
    chk("sw5_no_done", swap_done, 0);
    chk("sw5_front_hold", front_sel, 0);
    chk("sw5_pending", swap_pending, 1);
    swap_req    = 1'b1;
    clear_req   = 1'b1;
    clear_color = 24'h0000FF;
    vs_in       = 1'b1;
    nclk();
    swap_req  = 1'b0;
    clear_req = 1'b0;
    chk("sw5_clr_ignored", clear_busy, 0);
    chk("sw5_still_wait", front_sel, 0);
    vs_in = 1'b0;
    nclk();
    chk("sw5_done", swap_done, 1);
    chk("sw5_front", front_sel, 1);
    rd_addr = 15'd5;
    nclk();
    chk("sw5_rd_bank1", rd_data, 24'hFF0000);
    chk("sw5_pending_clr", swap_pending, 0);
    chk("sw5_ready", wr_if.wr_ready, 1);

    // reset in the middle of a clear
    clear_req   = 1'b1;
    clear_color = 24'h123456;
    nclk();
    clear_req = 1'b0;
    repeat (1000) nclk();
    swap_req = 1'b1;
    nclk();
    swap_req = 1'b0;
    chk("mid_busy", clear_busy, 1);
    chk("mid_pending", swap_pending, 1);
    reset_n = 1'b0;
    #1;
    chk("arst_busy", clear_busy, 0);
    chk("arst_ready", wr_if.wr_ready, 0);
    chk("arst_front", front_sel, 0);
    chk("arst_pending", swap_pending, 0);
    chk("arst_rd_data", rd_data, 0);
    nclk();
    reset_n = 1'b1;
    nclk();
    chk("rel_ready", wr_if.wr_ready, 1);
    chk("rel_busy", clear_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
